// File: rtl/button_decoder.sv
// Debounces an encoded 3-bit button code into one-hot direction pulses and levels.
// Define BUTTON_AUTO_REPEAT_EN to add auto-repeat pulses while a direction is held.
module button_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_code,
  output logic [3:0] move_pulse,
  output logic [3:0] held,
  output logic       code_err
);

  localparam int unsigned     DB_W   = 16;
  localparam int unsigned     SEEN_W = DB_W + 1;
  localparam logic [DB_W-1:0] DB_MAX = '1;

  function automatic logic is_dir(input logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd4);
  endfunction

  function automatic logic is_ill(input logic [2:0] c);
    return c >= 3'd5;
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [2:0] c);
    logic [3:0] oh;
    case (c)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned      RPT_W       = 20;
  localparam logic [RPT_W-1:0] RPT_MAX     = '1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [2:0]      cand_q, cand_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [SEEN_W-1:0] seen;
  logic [2:0]      acc_q, acc_d;
  logic            acc_ill_q, acc_ill_d;
  logic [2:0]      dir_q, dir_d;
  logic [3:0]      ev_pulse_q, ev_pulse_d;
  logic            ev_err_q, ev_err_d;
  logic [3:0]      move_pulse_q;
  logic [3:0]      held_q, held_d;
  logic            code_err_q;

  // Input filter: db_cnt holds (run length - 1) of the current candidate.
  always_comb begin
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    seen     = '0;
    if (button_code != cand_q) begin
      cand_d   = button_code;
      db_cnt_d = '0;
      seen     = SEEN_W'(1);
    end else begin
      if (db_cnt_q != DB_MAX) begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
      seen = SEEN_W'(db_cnt_q) + SEEN_W'(2);
    end
    if (seen >= SEEN_W'(DEBOUNCE_CYCLES)) begin
      acc_d = button_code;
    end
  end

  // Press FSM; events are staged one cycle before they reach the outputs.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ev_pulse_d = 4'b0000;
    ev_err_d   = is_ill(acc_q) && !acc_ill_q;
    acc_ill_d  = is_ill(acc_q);
`ifdef BUTTON_AUTO_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (is_dir(acc_q)) begin
          state_d    = ST_PRESSED;
          dir_d      = acc_q;
          ev_pulse_d = dir_onehot(acc_q);
`ifdef BUTTON_AUTO_REPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end
      end
      // Active states share release and direction-change handling.
      default: begin
        if (!is_dir(acc_q)) begin
          state_d = ST_IDLE;
          dir_d   = 3'd0;
        end else if (acc_q != dir_q) begin
          state_d    = ST_PRESSED;
          dir_d      = acc_q;
          ev_pulse_d = dir_onehot(acc_q);
`ifdef BUTTON_AUTO_REPEAT_EN
          rpt_cnt_d  = '0;
        end else if (rpt_cnt_q == ((state_q == ST_REPEAT) ? PERIOD_LAST : DELAY_LAST)) begin
          state_d    = ST_REPEAT;
          ev_pulse_d = dir_onehot(dir_q);
          rpt_cnt_d  = '0;
        end else if (rpt_cnt_q != RPT_MAX) begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
`endif
        end
      end
    endcase
    held_d = (state_d == ST_IDLE) ? 4'b0000 : dir_onehot(dir_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_q       <= 3'd0;
      db_cnt_q     <= '0;
      acc_q        <= 3'd0;
      acc_ill_q    <= 1'b0;
      dir_q        <= 3'd0;
      ev_pulse_q   <= 4'b0000;
      ev_err_q     <= 1'b0;
      move_pulse_q <= 4'b0000;
      held_q       <= 4'b0000;
      code_err_q   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      db_cnt_q     <= db_cnt_d;
      acc_q        <= acc_d;
      acc_ill_q    <= acc_ill_d;
      dir_q        <= dir_d;
      ev_pulse_q   <= ev_pulse_d;
      ev_err_q     <= ev_err_d;
      move_pulse_q <= ev_pulse_q;
      held_q       <= held_d;
      code_err_q   <= ev_err_q;
`ifdef BUTTON_AUTO_REPEAT_EN
      rpt_cnt_q    <= rpt_cnt_d;
`endif
    end
  end

  assign move_pulse = move_pulse_q;
  assign held       = held_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_button_decoder.sv
// Bench for button_decoder: directed vector table, hand-written corner sequences,
// and randomized stimulus against a run-length/hold-age reference model.
module tb_button_decoder;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] button_code = 3'd0;
  logic [3:0] move_pulse;
  logic [3:0] held;
  logic       code_err;

  button_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_code(button_code),
    .move_pulse (move_pulse),
    .held       (held),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       rst;
    logic [2:0] code;
    logic [3:0] mv;
    logic [3:0] hd;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [3:0] mv,
                              input logic [3:0] hd, input logic er);
    vec_t v;
    v.rst = r; v.code = c; v.mv = mv; v.hd = hd; v.er = er;
    return v;
  endfunction

  function automatic logic [3:0] oh(input logic [2:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return (c >= 3'd1 && c <= 3'd4) ? (one << (c - 3'd1)) : 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [2:0] c);
    reset = r;
    button_code = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted code from input run length, hold age drives repeats.
  int         run_len;
  logic [2:0] run_val;
  logic [2:0] m_acc;
  logic       m_prev_ill;
  logic [2:0] m_dir;
  int         m_since;
  logic [3:0] m_ev;
  logic       m_everr;
  logic [3:0] e_move, e_held;
  logic       e_err;

  task automatic model_edge(input logic r, input logic [2:0] c);
    logic [2:0] nd;
    logic       ill;
    if (r) begin
      run_len = 0; run_val = 3'd0; m_acc = 3'd0; m_prev_ill = 1'b0;
      m_dir = 3'd0; m_since = 0; m_ev = 4'b0; m_everr = 1'b0;
      e_move = 4'b0; e_held = 4'b0; e_err = 1'b0;
    end else begin
      e_move = m_ev;
      e_err  = m_everr;
      nd = (m_acc >= 3'd1 && m_acc <= 3'd4) ? m_acc : 3'd0;
      m_ev = 4'b0;
      if (nd == 3'd0) begin
        m_since = 0;
      end else if (nd != m_dir) begin
        m_since = 0;
        m_ev = oh(nd);
      end else begin
        m_since++;
`ifdef BUTTON_AUTO_REPEAT_EN
        if (m_since >= int'(RD) && ((m_since - int'(RD)) % int'(RP)) == 0) m_ev = oh(nd);
`endif
      end
      m_dir  = nd;
      e_held = oh(nd);
      ill = (m_acc >= 3'd5);
      m_everr = ill && !m_prev_ill;
      m_prev_ill = ill;
      if (run_len > 0 && c == run_val) run_len++;
      else begin
        run_val = c;
        run_len = 1;
      end
      if (run_len >= int'(DB)) m_acc = c;
    end
  endtask

  initial begin
    int pulses[$];
    int exp_edges[$];
    int first;
    logic [3:0] first_val;
    logic [2:0] cur;
    int run;
    logic r;

    // Press, direction switch, short glitch, exact-threshold press, illegal code.
    tbl.push_back(mk(1'b1, 3'd0, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 8; e++)
      tbl.push_back(mk(1'b0, 3'd1, (e == 5) ? 4'b0001 : 4'b0, (e >= 4) ? 4'b0001 : 4'b0, 1'b0));
    for (int s = 0; s < 7; s++)
      tbl.push_back(mk(1'b0, 3'd4, (s == 5) ? 4'b1000 : 4'b0, (s >= 4) ? 4'b1000 : 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 3; e++) tbl.push_back(mk(1'b0, 3'd2, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 6; e++) tbl.push_back(mk(1'b0, 3'd0, 4'b0, 4'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 8; e++)
      tbl.push_back(mk(1'b0, 3'd1, (e == 5) ? 4'b0001 : 4'b0, (e >= 4) ? 4'b0001 : 4'b0, 1'b0));
    for (int e = 0; e < 3; e++) tbl.push_back(mk(1'b0, 3'd0, 4'b0, 4'b0001, 1'b0));
    for (int e = 0; e < 8; e++) tbl.push_back(mk(1'b0, 3'd1, 4'b0, 4'b0001, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 10; e++)
      tbl.push_back(mk(1'b0, (e < 4) ? 3'd2 : 3'd0, (e == 5) ? 4'b0010 : 4'b0,
                       (e >= 4 && e <= 7) ? 4'b0010 : 4'b0, 1'b0));
    tbl.push_back(mk(1'b1, 3'd0, 4'b0, 4'b0, 1'b0));
    for (int e = 0; e < 7; e++) tbl.push_back(mk(1'b0, 3'd6, 4'b0, 4'b0, e == 5));

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].code);
      chk($sformatf("tbl[%0d].move_pulse", i), move_pulse, tbl[i].mv);
      chk($sformatf("tbl[%0d].held", i), held, tbl[i].hd);
      chk($sformatf("tbl[%0d].code_err", i), {3'b0, code_err}, {3'b0, tbl[i].er});
    end

    // Long hold of "down": record every pulse edge.
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_edges = '{5, 25, 33, 41, 49, 57};
`else
    exp_edges = '{5};
`endif
    tick(1'b1, 3'd0);
    for (int e = 0; e < 60; e++) begin
      tick(1'b0, 3'd3);
      if (move_pulse != 4'b0) begin
        pulses.push_back(e);
        chk($sformatf("hold.pulse_val@%0d", e), move_pulse, 4'b0100);
      end
    end
    chk_int("hold.pulse_count", pulses.size(), exp_edges.size());
    foreach (exp_edges[i])
      chk_int($sformatf("hold.pulse_edge[%0d]", i), (i < pulses.size()) ? pulses[i] : -1, exp_edges[i]);

    // Reset mid-press: silence, then full re-debounce and a single pulse.
    tick(1'b1, 3'd0);
    for (int e = 0; e < 10; e++) tick(1'b0, 3'd1);
    tick(1'b1, 3'd1);
    chk("rst.move@10", move_pulse, 4'b0);
    chk("rst.held@10", held, 4'b0);
    tick(1'b0, 3'd1);
    chk("rst.move@11", move_pulse, 4'b0);
    chk("rst.held@11", held, 4'b0);
    chk("rst.err@11", {3'b0, code_err}, 4'b0);
    first = -1;
    first_val = 4'b0;
    for (int e = 12; e < 30; e++) begin
      tick(1'b0, 3'd1);
      if (move_pulse != 4'b0 && first < 0) begin
        first = e;
        first_val = move_pulse;
      end
    end
    chk_int("rst.first_pulse_edge", first, 16);
    chk("rst.first_pulse_val", first_val, 4'b0001);

    // Randomized runs against the reference model.
    tick(1'b1, 3'd0);
    model_edge(1'b1, 3'd0);
    cur = 3'd0;
    run = 0;
    for (int t = 0; t < 4000; t++) begin
      if (run == 0) begin
        cur = 3'($urandom_range(0, 7));
        run = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
      end
      run--;
      r = ($urandom_range(0, 299) == 0);
      tick(r, cur);
      model_edge(r, cur);
      chk($sformatf("rand[%0d].move_pulse", t), move_pulse, e_move);
      chk($sformatf("rand[%0d].held", t), held, e_held);
      chk($sformatf("rand[%0d].code_err", t), {3'b0, code_err}, {3'b0, e_err});
      chk_int($sformatf("rand[%0d].exclusive", t),
              int'($countones(move_pulse) <= 1 && !(move_pulse != 4'b0 && code_err)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
